ahb_master: RTL and testbench
=============================

AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 Parameter addrWidth, default 8, SHALL set the width of haddr and cmd_addr.
REQ-002 Parameter dataWidth, default 32, SHALL set the width of hwdata, hrdata, cmd_wdata and rsp_rdata.
REQ-003 hclk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 hreset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  SHALL indicate a transfer request is offered.
REQ-006 cmd_ready  output  1  SHALL indicate the request is accepted this cycle; combinational, equal to hready while hreset is low.
REQ-007 cmd_write  input  1  SHALL select write (1) or read (0).
REQ-008 cmd_addr  input  addrWidth  SHALL give the transfer address.
REQ-009 cmd_wdata  input  dataWidth  SHALL give the write data, sampled at acceptance.
REQ-010 rsp_valid  output  1  SHALL pulse one cycle when a read completes.
REQ-011 rsp_rdata  output  dataWidth  SHALL carry read data while rsp_valid is high.
REQ-012 wr_done  output  1  SHALL pulse one cycle when a write completes.
REQ-013 htrans  output  2  SHALL drive IDLE (2'b00) or NONSEQ (2'b10) only.
REQ-014 haddr, hwrite  output  addrWidth, 1  SHALL drive the address-phase address and direction.
REQ-015 hwdata  output  dataWidth  SHALL drive the data-phase write data.
REQ-016 hready  input  1  SHALL be the slave ready; low stalls both phases.
REQ-017 hrdata  input  dataWidth  SHALL be the slave read data, valid in the data phase.

Function
REQ-018 Acceptance: a command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
REQ-019 At acceptance: htrans<=NONSEQ, haddr<=cmd_addr, hwrite<=cmd_write, wdata captured internally; the following cycle is the address phase.
REQ-020 With no acceptance and hready=1: htrans<=IDLE; haddr and hwrite hold their last values.
REQ-021 Address phase SHALL complete on the first edge with hready=1; the transfer then enters its data phase (data-phase valid flag, direction and wdata registered).
REQ-022 Write data phase: hwdata SHALL equal the captured wdata for the whole data phase, including stall cycles.
REQ-023 Data phase SHALL complete on the first edge with hready=1; a read SHALL register rsp_valid=1, rsp_rdata=hrdata; a write SHALL register wr_done=1; both outputs are registered, so they assert the cycle after that edge.
REQ-024 Pipelining: the data phase of transfer N SHALL overlap the address phase of transfer N+1; back-to-back commands SHALL sustain one transfer per cycle.
REQ-025 Latency: with hready=1 throughout, rsp_valid/wr_done SHALL assert exactly 3 cycles after the acceptance edge.
REQ-026 Stall: while hready=0, htrans, haddr, hwrite, hwdata and all phase state SHALL hold, and no response pulse SHALL be generated.
REQ-027 rsp_valid and wr_done SHALL never be high in the same cycle; each is deasserted in any cycle without a completion.
REQ-028 rsp_rdata SHALL hold its last value when rsp_valid is low.
REQ-029 Mixed read-after-write and write-after-read sequences SHALL complete in issue order with no bubbles.

Reset
REQ-030 hreset=1 SHALL immediately force htrans=IDLE, haddr=0, hwrite=0, hwdata=0, rsp_valid=0, rsp_rdata=0, wr_done=0, clear both phase-valid flags, and force cmd_ready=0.
REQ-031 Transfers in flight at reset SHALL be discarded with no response pulse.
REQ-032 After hreset deasserts, cmd_ready SHALL follow hready.

Verification
REQ-033 Single write addr 0x10 data 0xDEADBEEF, hready=1 -> NONSEQ/0x10/hwrite=1 one cycle, hwdata=0xDEADBEEF next cycle, wr_done 3 cycles after acceptance.
REQ-034 Write 0x22 then read 0x22 back-to-back against ahb_slave -> rsp_valid once, rsp_rdata=value written, no IDLE cycle between transfers.
REQ-035 Four back-to-back reads 0x00..0x03 -> four consecutive rsp_valid pulses in address order.
REQ-036 Read 0x05 with hready held low 2 cycles in its data phase -> htrans/haddr/hwdata stable during stall, rsp_valid delayed exactly 2 cycles.
REQ-037 hreset asserted mid-transfer (write in data phase, read in address phase) -> outputs at reset values asynchronously, no wr_done/rsp_valid afterwards.
REQ-038 cmd_valid=1 while hready=0 -> cmd_ready=0, no acceptance until hready=1.

Source files
------------

// File: rtl/ahb_master_if.sv
// Command/response and AHB-Lite bus signals for ahb_master.
// The master modport is the bus master side; slave is its mirror.
interface ahb_master_if #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [addrWidth-1:0] cmd_addr;
    logic [dataWidth-1:0] cmd_wdata;
    logic                 rsp_valid;
    logic [dataWidth-1:0] rsp_rdata;
    logic                 wr_done;
    logic [1:0]           htrans;
    logic [addrWidth-1:0] haddr;
    logic                 hwrite;
    logic [dataWidth-1:0] hwdata;
    logic                 hready;
    logic [dataWidth-1:0] hrdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  hready, hrdata,
        output cmd_ready, rsp_valid, rsp_rdata, wr_done,
        output htrans, haddr, hwrite, hwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output hready, hrdata,
        input  cmd_ready, rsp_valid, rsp_rdata, wr_done,
        input  htrans, haddr, hwrite, hwdata
    );
endinterface

// File: rtl/ahb_master.sv
// Pipelined single-transfer AHB-Lite master: one NONSEQ per accepted
// command, address phase overlapping the previous data phase.
module ahb_master #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32
) (
    input logic hclk,
    input logic hreset,
    ahb_master_if.master bus
);
    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    logic [1:0]           htrans_q, htrans_d;
    logic [addrWidth-1:0] haddr_q, haddr_d;
    logic                 hwrite_q, hwrite_d;
    logic [dataWidth-1:0] wdata_q, wdata_d;
    logic                 dp_valid_q, dp_valid_d;
    logic                 dp_write_q, dp_write_d;
    logic [dataWidth-1:0] hwdata_q, hwdata_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 wr_done_q, wr_done_d;
    logic                 ap_valid;
    logic                 accept;

    // A command can only enter when the bus is advancing and not in reset.
    assign bus.cmd_ready = bus.hready & ~hreset;
    assign accept        = bus.cmd_valid & bus.cmd_ready;
    assign ap_valid      = (htrans_q == TransNonseq);

    // Next state: every phase advances together on hready, else all hold.
    always_comb begin
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        wdata_d     = wdata_q;
        dp_valid_d  = dp_valid_q;
        dp_write_d  = dp_write_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        wr_done_d   = 1'b0;
        if (bus.hready) begin
            dp_valid_d = ap_valid;
            dp_write_d = hwrite_q;
            if (ap_valid && hwrite_q) begin
                hwdata_d = wdata_q;
            end
            if (dp_valid_q) begin
                if (dp_write_q) begin
                    wr_done_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus.hrdata;
                end
            end
            if (accept) begin
                htrans_d = TransNonseq;
                haddr_d  = bus.cmd_addr;
                hwrite_d = bus.cmd_write;
                wdata_d  = bus.cmd_wdata;
            end else begin
                htrans_d = TransIdle;
            end
        end
    end

    // State registers; reset discards any transfer in flight.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            htrans_q    <= TransIdle;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            wdata_q     <= '0;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            wr_done_q   <= 1'b0;
        end else begin
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            wdata_q     <= wdata_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            wr_done_q   <= wr_done_d;
        end
    end

    assign bus.htrans    = htrans_q;
    assign bus.haddr     = haddr_q;
    assign bus.hwrite    = hwrite_q;
    assign bus.hwdata    = hwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.wr_done   = wr_done_q;
endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: directed commands against a small memory slave,
// responses checked by a scoreboard monitor for order, data and cycle.
module tb_ahb_master;
    logic hclk = 1'b0;
    logic hreset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ahb_master_if #(.addrWidth(8), .dataWidth(32)) bus ();

    ahb_master #(.addrWidth(8), .dataWidth(32)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc <= cyc + 1;

    // Memory slave, always ready unless the bench stalls hready.
    logic [31:0] mem [256];
    logic        sl_dp_q;
    logic        sl_wr_q;
    logic [7:0]  sl_addr_q;

    always @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            sl_dp_q   <= 1'b0;
            sl_wr_q   <= 1'b0;
            sl_addr_q <= 8'h00;
        end else if (bus.hready) begin
            sl_dp_q   <= (bus.htrans == 2'b10);
            sl_wr_q   <= bus.hwrite;
            sl_addr_q <= bus.haddr;
        end
    end

    always @(posedge hclk) begin
        if (!hreset && bus.hready && sl_dp_q && sl_wr_q)
            mem[sl_addr_q] <= bus.hwdata;
    end

    assign bus.hrdata = sl_dp_q ? mem[sl_addr_q] : 32'h0;

    typedef struct {
        logic        wr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one command at a negedge; it is accepted on the next edge.
    task automatic issue(input logic wr, input logic [7:0] a,
                         input logic [31:0] d, input logic [31:0] rexp,
                         input int extra, input bit push);
        exp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = wr ? d : 32'h0;
        bus.hready    = 1'b1;
        e.wr   = wr;
        e.data = wr ? 32'h0 : rexp;
        e.cyc  = cyc + 1 + 2 + extra;
        if (push) sb.push_back(e);
        @(negedge hclk);
    endtask

    task automatic idle(input int n);
        bus.cmd_valid = 1'b0;
        bus.hready    = 1'b1;
        repeat (n) @(negedge hclk);
    endtask

    // Monitor: every response pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge hclk);
            #1;
            if (!hreset) begin
                checks++;
                if (bus.rsp_valid && bus.wr_done) begin
                    errors++;
                    $display("FAIL both_pulses cyc %0d", cyc);
                end
                if (bus.rsp_valid || bus.wr_done) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rsp cyc %0d wr %0b",
                                 cyc, bus.wr_done);
                    end else begin
                        e = sb.pop_front();
                        if (e.wr !== bus.wr_done || e.cyc != cyc ||
                            (!e.wr && bus.rsp_rdata !== e.data)) begin
                            errors++;
                            $display("FAIL rsp got wr %0b data %h cyc %0d want wr %0b data %h cyc %0d",
                                     bus.wr_done, bus.rsp_rdata, cyc,
                                     e.wr, e.data, e.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] hw;
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 32'h0;
        bus.hready    = 1'b1;
        #2 hreset = 1'b1;
        repeat (2) @(negedge hclk);
        chk("rst_htrans", {30'd0, bus.htrans}, 32'h0);
        chk("rst_haddr", {24'd0, bus.haddr}, 32'h0);
        chk("rst_hwrite", {31'd0, bus.hwrite}, 32'h0);
        chk("rst_hwdata", bus.hwdata, 32'h0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_wr_done", {31'd0, bus.wr_done}, 32'h0);
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'h0);
        hreset = 1'b0;
        #1 chk("post_rst_ready", {31'd0, bus.cmd_ready}, 32'h1);
        @(negedge hclk);

        // Single write
        issue(1'b1, 8'h10, 32'hDEADBEEF, 32'h0, 0, 1'b1);
        chk("w1_htrans", {30'd0, bus.htrans}, 32'h2);
        chk("w1_haddr", {24'd0, bus.haddr}, 32'h10);
        chk("w1_hwrite", {31'd0, bus.hwrite}, 32'h1);
        idle(1);
        chk("w1_idle", {30'd0, bus.htrans}, 32'h0);
        chk("w1_hwdata", bus.hwdata, 32'hDEADBEEF);
        idle(4);

        // Write then read-back, back to back
        issue(1'b1, 8'h22, 32'h12345678, 32'h0, 0, 1'b1);
        issue(1'b0, 8'h22, 32'h0, 32'h12345678, 0, 1'b1);
        chk("raw_htrans", {30'd0, bus.htrans}, 32'h2);
        chk("raw_haddr", {24'd0, bus.haddr}, 32'h22);
        chk("raw_hwrite", {31'd0, bus.hwrite}, 32'h0);
        idle(4);

        // Four consecutive reads
        for (int i = 0; i < 4; i++)
            issue(1'b0, 8'(i), 32'h0, 32'hC0DE0000 | i, 0, 1'b1);
        idle(5);

        // Read with two stall cycles in its data phase
        issue(1'b0, 8'h05, 32'h0, 32'hC0DE0005, 2, 1'b1);
        idle(1);
        bus.hready = 1'b0;
        hw = bus.hwdata;
        for (int i = 0; i < 2; i++) begin
            @(negedge hclk);
            chk("st_htrans", {30'd0, bus.htrans}, 32'h0);
            chk("st_haddr", {24'd0, bus.haddr}, 32'h05);
            chk("st_hwdata", bus.hwdata, hw);
            chk("st_rsp_valid", {31'd0, bus.rsp_valid}, 32'h0);
            chk("st_rsp_rdata", bus.rsp_rdata, 32'hC0DE0003);
            chk("st_cmd_ready", {31'd0, bus.cmd_ready}, 32'h0);
        end
        idle(4);

        // Command offered while hready is low
        bus.hready    = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 8'h30;
        bus.cmd_wdata = 32'h0BADF00D;
        #1 chk("hold_ready", {31'd0, bus.cmd_ready}, 32'h0);
        @(negedge hclk);
        chk("hold_htrans", {30'd0, bus.htrans}, 32'h0);
        chk("hold_ready2", {31'd0, bus.cmd_ready}, 32'h0);
        issue(1'b1, 8'h30, 32'h0BADF00D, 32'h0, 0, 1'b1);
        chk("hold_acc_htrans", {30'd0, bus.htrans}, 32'h2);
        chk("hold_acc_haddr", {24'd0, bus.haddr}, 32'h30);
        issue(1'b0, 8'h30, 32'h0, 32'h0BADF00D, 0, 1'b1);
        idle(5);

        // Reset with a write in data phase and a read in address phase
        issue(1'b1, 8'h40, 32'h55AA55AA, 32'h0, 0, 1'b0);
        issue(1'b0, 8'h41, 32'h0, 32'h0, 0, 1'b0);
        bus.cmd_valid = 1'b0;
        hreset = 1'b1;
        #1;
        chk("mr_htrans", {30'd0, bus.htrans}, 32'h0);
        chk("mr_haddr", {24'd0, bus.haddr}, 32'h0);
        chk("mr_hwrite", {31'd0, bus.hwrite}, 32'h0);
        chk("mr_hwdata", bus.hwdata, 32'h0);
        chk("mr_rsp_valid", {31'd0, bus.rsp_valid}, 32'h0);
        chk("mr_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("mr_wr_done", {31'd0, bus.wr_done}, 32'h0);
        chk("mr_cmd_ready", {31'd0, bus.cmd_ready}, 32'h0);
        repeat (2) @(negedge hclk);
        hreset = 1'b0;
        #1 chk("mr_ready_back", {31'd0, bus.cmd_ready}, 32'h1);
        idle(8);
        chk("sb_empty", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
